// File: rtl/buffered_router.sv
// rtl/buffered_router.sv - 1-to-NUM_PORTS router with a FIFO on each output port
// Optional per-port accepted-word counters: define ROUTER_STATS_EN.
module buffered_router #(
  parameter int WIDTH      = 32,
  parameter int NUM_PORTS  = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int AW = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       din_en,
  output logic                       din_ready,
  input  logic [AW-1:0]              addr,
  input  logic [WIDTH-1:0]           din,
  output logic [NUM_PORTS*WIDTH-1:0] dout,
  output logic [NUM_PORTS-1:0]       dout_valid,
  input  logic [NUM_PORTS-1:0]       dout_ready,
  output logic [15:0]                drop_cnt
`ifdef ROUTER_STATS_EN
  ,
  output logic [NUM_PORTS*16-1:0]    pkt_cnt,
  input  logic                       stats_clr
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [WIDTH-1:0] mem_q [NUM_PORTS][FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q [NUM_PORTS];
  logic [PW-1:0]    wr_ptr_d [NUM_PORTS];
  logic [PW-1:0]    rd_ptr_q [NUM_PORTS];
  logic [PW-1:0]    rd_ptr_d [NUM_PORTS];
  logic [CW-1:0]    count_q  [NUM_PORTS];
  logic [CW-1:0]    count_d  [NUM_PORTS];
  logic [15:0]      drop_cnt_q, drop_cnt_d;
  logic [NUM_PORTS-1:0] full, empty, push, pop;
  logic             addr_ok, accept, clr;

`ifdef ROUTER_STATS_EN
  logic [15:0] pkt_cnt_q [NUM_PORTS];
  logic [15:0] pkt_cnt_d [NUM_PORTS];
  assign clr = stats_clr;
`else
  assign clr = 1'b0;
`endif

  always_comb begin
    addr_ok    = (32'(addr) < NUM_PORTS);
    for (int p = 0; p < NUM_PORTS; p++) begin
      full[p]  = (count_q[p] == CW'(FIFO_DEPTH));
      empty[p] = (count_q[p] == '0);
    end
    // Out-of-range words are always taken so they can be counted and dropped.
    din_ready  = addr_ok ? !full[addr] : 1'b1;
    accept     = din_en & din_ready;
    drop_cnt_d = drop_cnt_q;
    if (clr)
      drop_cnt_d = '0;
    else if (accept && !addr_ok && drop_cnt_q != 16'hFFFF)
      drop_cnt_d = drop_cnt_q + 16'd1;
    for (int p = 0; p < NUM_PORTS; p++) begin
      push[p]     = accept & addr_ok & (addr == AW'(p));
      pop[p]      = !empty[p] & dout_ready[p];
      wr_ptr_d[p] = push[p] ? wr_ptr_q[p] + PW'(1) : wr_ptr_q[p];
      rd_ptr_d[p] = pop[p]  ? rd_ptr_q[p] + PW'(1) : rd_ptr_q[p];
      count_d[p]  = count_q[p];
      if (push[p] && !pop[p])
        count_d[p] = count_q[p] + CW'(1);
      else if (!push[p] && pop[p])
        count_d[p] = count_q[p] - CW'(1);
      dout_valid[p]              = !empty[p];
      dout[p*WIDTH +: WIDTH]     = empty[p] ? '0 : mem_q[p][rd_ptr_q[p]];
`ifdef ROUTER_STATS_EN
      pkt_cnt_d[p] = pkt_cnt_q[p];
      if (clr)
        pkt_cnt_d[p] = '0;
      else if (push[p] && pkt_cnt_q[p] != 16'hFFFF)
        pkt_cnt_d[p] = pkt_cnt_q[p] + 16'd1;
      pkt_cnt[p*16 +: 16] = pkt_cnt_q[p];
`endif
    end
  end

  assign drop_cnt = drop_cnt_q;

  // Storage needs no reset: the head is masked to zero whenever a FIFO is empty.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++)
      if (push[p]) mem_q[p][wr_ptr_q[p]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        wr_ptr_q[p] <= '0;
        rd_ptr_q[p] <= '0;
        count_q[p]  <= '0;
`ifdef ROUTER_STATS_EN
        pkt_cnt_q[p] <= '0;
`endif
      end
    end else begin
      drop_cnt_q <= drop_cnt_d;
      for (int p = 0; p < NUM_PORTS; p++) begin
        wr_ptr_q[p] <= wr_ptr_d[p];
        rd_ptr_q[p] <= rd_ptr_d[p];
        count_q[p]  <= count_d[p];
`ifdef ROUTER_STATS_EN
        pkt_cnt_q[p] <= pkt_cnt_d[p];
`endif
      end
    end
  end

endmodule

// File: tb/tb_buffered_router.sv
// tb/tb_buffered_router.sv - directed self-checking bench for buffered_router
// Also exercises ROUTER_STATS_EN counters when that macro is defined.
module tb_buffered_router;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         din_en;
  logic         din_ready;
  logic [1:0]   addr;
  logic [31:0]  din;
  logic [127:0] dout;
  logic [3:0]   dout_valid;
  logic [3:0]   dout_ready;
  logic [15:0]  drop_cnt;

  logic         din_en3;
  logic         din_ready3;
  logic [1:0]   addr3;
  logic [31:0]  din3;
  logic [95:0]  dout3;
  logic [2:0]   dout_valid3;
  logic [2:0]   dout_ready3;
  logic [15:0]  drop_cnt3;

`ifdef ROUTER_STATS_EN
  logic [63:0]  pkt_cnt;
  logic [47:0]  pkt_cnt3;
  logic         stats_clr;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  buffered_router #(.WIDTH(32), .NUM_PORTS(4), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .din_en(din_en), .din_ready(din_ready),
    .addr(addr), .din(din), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .drop_cnt(drop_cnt)
`ifdef ROUTER_STATS_EN
    , .pkt_cnt(pkt_cnt), .stats_clr(stats_clr)
`endif
  );

  buffered_router #(.WIDTH(32), .NUM_PORTS(3), .FIFO_DEPTH(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .din_en(din_en3), .din_ready(din_ready3),
    .addr(addr3), .din(din3), .dout(dout3), .dout_valid(dout_valid3),
    .dout_ready(dout_ready3), .drop_cnt(drop_cnt3)
`ifdef ROUTER_STATS_EN
    , .pkt_cnt(pkt_cnt3), .stats_clr(stats_clr)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] a, input logic [31:0] d);
    din_en = 1'b1;
    addr   = a;
    din    = d;
    tick();
    din_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; din_en = 1'b0; addr = '0; din = '0; dout_ready = '0;
    din_en3 = 1'b0; addr3 = '0; din3 = '0; dout_ready3 = '0;
`ifdef ROUTER_STATS_EN
    stats_clr = 1'b0;
`endif
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("reset_valid", 128'(dout_valid), 128'h0);
    chk("reset_dout", dout, 128'h0);
    chk("reset_ready", 128'(din_ready), 128'h1);
    chk("reset_drop", 128'(drop_cnt), 128'h0);

    push(2'd0, 32'hAA);
    chk("p0_valid", 128'(dout_valid), 128'h1);
    chk("p0_data", 128'(dout[31:0]), 128'hAA);
    push(2'd1, 32'hCC);
    chk("p1_valid", 128'(dout_valid), 128'h3);
    chk("p1_data", 128'(dout[63:32]), 128'hCC);
    push(2'd2, 32'hF0);
    chk("p2_valid", 128'(dout_valid), 128'h7);
    chk("p2_data", 128'(dout[95:64]), 128'hF0);
    push(2'd3, 32'h0F);
    chk("p3_valid", 128'(dout_valid), 128'hF);
    chk("p3_data", 128'(dout[127:96]), 128'h0F);
    chk("p0_held", 128'(dout[31:0]), 128'hAA);

    dout_ready = 4'hF;
    tick();
    dout_ready = 4'h0;
    chk("drain_valid", 128'(dout_valid), 128'h0);
    chk("drain_zero", dout, 128'h0);

    for (int i = 1; i <= 4; i++) push(2'd2, 32'(i));
    addr = 2'd2; #1;
    chk("full2_ready", 128'(din_ready), 128'h0);
    addr = 2'd0; #1;
    chk("other_ready", 128'(din_ready), 128'h1);
    dout_ready = 4'b0100;
    for (int i = 1; i <= 4; i++) begin
      chk("p2_order", 128'(dout[95:64]), 128'(i));
      tick();
    end
    dout_ready = 4'h0;
    chk("p2_empty_valid", 128'(dout_valid[2]), 128'h0);
    chk("p2_empty_zero", 128'(dout[95:64]), 128'h0);

    for (int i = 0; i < 4; i++) push(2'd1, 32'h10 + 32'(i));
    din_en = 1'b1; addr = 2'd1; din = 32'h14; dout_ready = 4'b0010; #1;
    chk("full1_blocked", 128'(din_ready), 128'h0);
    tick();
    dout_ready = 4'h0; #1;
    chk("after_pop_ready", 128'(din_ready), 128'h1);
    chk("after_pop_head", 128'(dout[63:32]), 128'h11);
    tick();
    din_en = 1'b0; #1;
    chk("refull1_ready", 128'(din_ready), 128'h0);
    dout_ready = 4'b0010;
    for (int i = 1; i <= 4; i++) begin
      chk("p1_order", 128'(dout[63:32]), 128'h10 + 128'(i));
      tick();
    end
    dout_ready = 4'h0;
    chk("p1_empty", 128'(dout_valid[1]), 128'h0);

    din_en3 = 1'b1; addr3 = 2'b11; din3 = 32'hDEAD; #1;
    chk("bad_addr_ready", 128'(din_ready3), 128'h1);
    tick(); tick(); tick();
    din_en3 = 1'b0;
    chk("drop_cnt3", 128'(drop_cnt3), 128'h3);
    chk("drop_no_valid", 128'(dout_valid3), 128'h0);
    din_en3 = 1'b1; addr3 = 2'd2; din3 = 32'h33;
    tick();
    din_en3 = 1'b0;
    chk("n3_p2_valid", 128'(dout_valid3), 128'h4);
    chk("n3_p2_data", 128'(dout3[95:64]), 128'h33);
    chk("n3_drop_hold", 128'(drop_cnt3), 128'h3);

    for (int i = 0; i < 3; i++) push(2'd0, 32'h20 + 32'(i));
    chk("pre_rst_valid", 128'(dout_valid[0]), 128'h1);
    @(negedge clk);
    rst_n = 1'b0; #1;
    chk("async_rst_valid", 128'(dout_valid), 128'h0);
    chk("async_rst_dout", dout, 128'h0);
    chk("async_rst_drop3", 128'(drop_cnt3), 128'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", 128'(dout_valid[0]), 128'h0);
    chk("post_rst_ready", 128'(din_ready), 128'h1);

`ifdef ROUTER_STATS_EN
    dout_ready = 4'b1000;
    for (int i = 0; i < 5; i++) push(2'd3, 32'h50 + 32'(i));
    chk("pkt_cnt3_five", 128'(pkt_cnt[63:48]), 128'h5);
    chk("pkt_cnt0_zero", 128'(pkt_cnt[15:0]), 128'h0);
    stats_clr = 1'b1;
    push(2'd3, 32'h60);
    stats_clr = 1'b0;
    chk("pkt_cnt_clr", 128'(pkt_cnt), 128'h0);
    dout_ready = 4'h0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
